// File: rtl/cci_mpf_prim_repl_pkg.sv
// Shared types and helpers for the replacement-policy arbiter.
// Default geometry; the arbiter derives its own widths from its parameters.
package cci_mpf_prim_repl_pkg;

    localparam int unsigned REPL_N_WAYS     = 4;
    localparam int unsigned REPL_N_ENTRIES  = 1024;
    localparam int unsigned REPL_IDX_W      = $clog2(REPL_N_ENTRIES);
    localparam int unsigned REPL_WAY_IDX_W  = $clog2(REPL_N_WAYS);
    localparam int unsigned RR_MAX_REQ      = 32;

    typedef logic [REPL_IDX_W-1:0]     t_repl_set_idx;
    typedef logic [REPL_N_WAYS-1:0]    t_repl_way_vec;
    typedef logic [REPL_WAY_IDX_W-1:0] t_repl_way_idx;

    typedef struct packed {
        t_repl_set_idx idx;
        t_repl_way_vec vec;
    } t_repl_ref_entry;

    // One-hot winner: first set bit of req at or after ptr, wrapping within n requesters.
    function automatic logic [RR_MAX_REQ-1:0] rr_pick(input logic [RR_MAX_REQ-1:0] req,
                                                      input int unsigned ptr,
                                                      input int unsigned n);
        logic [RR_MAX_REQ-1:0] win;
        int unsigned j;
        win = '0;
        for (int unsigned i = 0; i < RR_MAX_REQ; i++) begin
            if (i < n) begin
                j = ptr + i;
                if (j >= n) j = j - n;
                if ((win == '0) && req[j]) win[j] = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/cci_mpf_prim_repl_ref_fifo.sv
// Reference-update FIFO: one push and up to two pops per cycle.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module cci_mpf_prim_repl_ref_fifo
#(
    parameter int unsigned DATA_W = 14,
    parameter int unsigned DEPTH  = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH)
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic [1:0]        pop_num,
    output logic [DATA_W-1:0] first,
    output logic [DATA_W-1:0] second,
    output logic [PTR_W:0]    count,
    output logic              can_push
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W:0]    wr_q;
    logic [PTR_W:0]    rd_q;
    logic [PTR_W-1:0]  rd_next_addr;
    logic              full;

    assign count        = wr_q - rd_q;
    assign full         = (wr_q[PTR_W] != rd_q[PTR_W]) &&
                          (wr_q[PTR_W-1:0] == rd_q[PTR_W-1:0]);
    // A full FIFO still has room once this cycle's pop is taken into account.
    assign can_push     = !full || (pop_num != 2'd0);
    assign rd_next_addr = rd_q[PTR_W-1:0] + 1'b1;
    assign first        = mem[rd_q[PTR_W-1:0]];
    assign second       = mem[rd_next_addr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + 1'b1;
            rd_q <= rd_q + (PTR_W+1)'(pop_num);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_q[PTR_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/cci_mpf_prim_repl_arb.sv
// Shares one replacement-policy instance among several requesters: round-robin
// victim lookups with routed responses, plus buffered best-effort reference updates.
module cci_mpf_prim_repl_arb
    import cci_mpf_prim_repl_pkg::*;
#(
    parameter int unsigned N_WAYS         = REPL_N_WAYS,
    parameter int unsigned N_ENTRIES      = REPL_N_ENTRIES,
    parameter int unsigned N_REQ          = 4,
    parameter int unsigned REF_FIFO_DEPTH = 8,
    localparam int unsigned IDX_W         = $clog2(N_ENTRIES),
    localparam int unsigned WAY_IDX_W     = $clog2(N_WAYS),
    localparam int unsigned REQ_W         = $clog2(N_REQ),
    localparam int unsigned CNT_W         = $clog2(REF_FIFO_DEPTH) + 1,
    localparam int unsigned ENTRY_W       = IDX_W + N_WAYS
)
(
    input  logic                           clk,
    input  logic                           reset,

    input  logic [N_REQ-1:0]               reqLookupEn,
    input  logic [N_REQ-1:0][IDX_W-1:0]    reqLookupIdx,
    output logic [N_REQ-1:0]               reqLookupGrant,
    output logic [N_REQ-1:0]               reqRspValid,
    output logic [N_WAYS-1:0]              reqRspVec,
    output logic [WAY_IDX_W-1:0]           reqRspIdx,

    input  logic [N_REQ-1:0]               reqRefEn,
    input  logic [N_REQ-1:0][IDX_W-1:0]    reqRefIdx,
    input  logic [N_REQ-1:0][N_WAYS-1:0]   reqRefWayVec,

    input  logic                           replRdy,
    output logic [IDX_W-1:0]               replLookupIdx,
    output logic                           replLookupEn,
    input  logic                           replLookupRspRdy,
    input  logic [N_WAYS-1:0]              replLookupVecRsp,
    input  logic [WAY_IDX_W-1:0]           replLookupRsp,

    output logic [IDX_W-1:0]               replRefIdx0,
    output logic [N_WAYS-1:0]              replRefWayVec0,
    output logic                           replRefEn0,
    output logic [IDX_W-1:0]               replRefIdx1,
    output logic [N_WAYS-1:0]              replRefWayVec1,
    output logic                           replRefEn1,

    output logic [15:0]                    refDropCnt
);

    // ---------------- Lookup arbitration and response routing ----------------
    logic [REQ_W-1:0]      lookup_ptr_q;
    logic [REQ_W-1:0]      owner_q;
    logic                  owner_vld_q;
    logic [RR_MAX_REQ-1:0] lookup_pick;
    logic [REQ_W-1:0]      lookup_win_id;

    always_comb begin
        lookup_pick    = rr_pick(RR_MAX_REQ'(reqLookupEn), 32'(lookup_ptr_q), N_REQ);
        reqLookupGrant = '0;
        if (replRdy) reqLookupGrant = lookup_pick[N_REQ-1:0];
        lookup_win_id = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (reqLookupGrant[i]) lookup_win_id = REQ_W'(i);
        end
    end

    assign replLookupEn  = |reqLookupGrant;
    assign replLookupIdx = reqLookupIdx[lookup_win_id];
    assign reqRspVec     = replLookupVecRsp;
    assign reqRspIdx     = replLookupRsp;

    // Reset is folded in so an in-flight response is squashed in the reset cycle itself.
    always_comb begin
        reqRspValid = '0;
        if (replLookupRspRdy && owner_vld_q && !reset) reqRspValid[owner_q] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lookup_ptr_q <= '0;
            owner_q      <= '0;
            owner_vld_q  <= 1'b0;
        end else begin
            owner_vld_q <= replLookupEn;
            if (replLookupEn) begin
                owner_q <= lookup_win_id;
                if (lookup_win_id == REQ_W'(N_REQ - 1)) lookup_ptr_q <= '0;
                else                                     lookup_ptr_q <= lookup_win_id + 1'b1;
            end
        end
    end

    // ---------------- Reference capture ----------------
    logic [REQ_W-1:0]      ref_ptr_q;
    logic [RR_MAX_REQ-1:0] ref_pick;
    logic [N_REQ-1:0]      ref_win;
    logic [REQ_W-1:0]      ref_win_id;
    logic                  ref_accept;
    logic [CNT_W-1:0]      fifo_count;
    logic                  fifo_can_push;
    logic [1:0]            pop_num;
    logic [ENTRY_W-1:0]    fifo_first;
    logic [ENTRY_W-1:0]    fifo_second;
    logic [15:0]           drop_cnt_q;
    logic [16:0]           drop_sum;
    int unsigned           drop_num;

    always_comb begin
        ref_pick   = rr_pick(RR_MAX_REQ'(reqRefEn), 32'(ref_ptr_q), N_REQ);
        ref_win    = ref_pick[N_REQ-1:0];
        ref_win_id = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (ref_win[i]) ref_win_id = REQ_W'(i);
        end
        // Drain only while the policy can absorb updates.
        pop_num = 2'd0;
        if (replRdy) begin
            if (fifo_count >= CNT_W'(2))      pop_num = 2'd2;
            else if (fifo_count == CNT_W'(1)) pop_num = 2'd1;
        end
        ref_accept = (|ref_win) && fifo_can_push;
        drop_num   = $countones(reqRefEn) - (ref_accept ? 1 : 0);
        drop_sum   = {1'b0, drop_cnt_q} + 17'(drop_num);
    end

    cci_mpf_prim_repl_ref_fifo #(
        .DATA_W (ENTRY_W),
        .DEPTH  (REF_FIFO_DEPTH)
    ) u_ref_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (ref_accept),
        .push_data ({reqRefIdx[ref_win_id], reqRefWayVec[ref_win_id]}),
        .pop_num   (pop_num),
        .first     (fifo_first),
        .second    (fifo_second),
        .count     (fifo_count),
        .can_push  (fifo_can_push)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            ref_ptr_q      <= '0;
            drop_cnt_q     <= '0;
            replRefEn0     <= 1'b0;
            replRefEn1     <= 1'b0;
            replRefIdx0    <= '0;
            replRefWayVec0 <= '0;
            replRefIdx1    <= '0;
            replRefWayVec1 <= '0;
        end else begin
            if (ref_accept) begin
                if (ref_win_id == REQ_W'(N_REQ - 1)) ref_ptr_q <= '0;
                else                                  ref_ptr_q <= ref_win_id + 1'b1;
            end
            drop_cnt_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            replRefEn0 <= (pop_num != 2'd0);
            replRefEn1 <= (pop_num == 2'd2);
            {replRefIdx0, replRefWayVec0} <= fifo_first;
            {replRefIdx1, replRefWayVec1} <= fifo_second;
        end
    end

    assign refDropCnt = drop_cnt_q;

endmodule

// File: tb/tb_cci_mpf_prim_repl_arb.sv
// Self-checking bench: scoreboards for lookup response routing and reference drain order.
module tb_cci_mpf_prim_repl_arb;

    logic             clk = 1'b0;
    logic             reset;
    logic [3:0]       reqLookupEn;
    logic [3:0][9:0]  reqLookupIdx;
    logic [3:0]       reqLookupGrant;
    logic [3:0]       reqRspValid;
    logic [3:0]       reqRspVec;
    logic [1:0]       reqRspIdx;
    logic [3:0]       reqRefEn;
    logic [3:0][9:0]  reqRefIdx;
    logic [3:0][3:0]  reqRefWayVec;
    logic             replRdy;
    logic [9:0]       replLookupIdx;
    logic             replLookupEn;
    logic             replLookupRspRdy;
    logic [3:0]       replLookupVecRsp;
    logic [1:0]       replLookupRsp;
    logic [9:0]       replRefIdx0;
    logic [3:0]       replRefWayVec0;
    logic             replRefEn0;
    logic [9:0]       replRefIdx1;
    logic [3:0]       replRefWayVec1;
    logic             replRefEn1;
    logic [15:0]      refDropCnt;

    int checks = 0;
    int passed = 0;
    int lk_q[$];
    logic [13:0] ref_q[$];

    cci_mpf_prim_repl_arb dut (
        .clk              (clk),
        .reset            (reset),
        .reqLookupEn      (reqLookupEn),
        .reqLookupIdx     (reqLookupIdx),
        .reqLookupGrant   (reqLookupGrant),
        .reqRspValid      (reqRspValid),
        .reqRspVec        (reqRspVec),
        .reqRspIdx        (reqRspIdx),
        .reqRefEn         (reqRefEn),
        .reqRefIdx        (reqRefIdx),
        .reqRefWayVec     (reqRefWayVec),
        .replRdy          (replRdy),
        .replLookupIdx    (replLookupIdx),
        .replLookupEn     (replLookupEn),
        .replLookupRspRdy (replLookupRspRdy),
        .replLookupVecRsp (replLookupVecRsp),
        .replLookupRsp    (replLookupRsp),
        .replRefIdx0      (replRefIdx0),
        .replRefWayVec0   (replRefWayVec0),
        .replRefEn0       (replRefEn0),
        .replRefIdx1      (replRefIdx1),
        .replRefWayVec1   (replRefWayVec1),
        .replRefEn1       (replRefEn1),
        .refDropCnt       (refDropCnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int model_pick(input logic [3:0] en, input int ptr);
        for (int k = 0; k < 4; k++) begin
            if (en[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        reqLookupEn = '0; reqLookupIdx = '0; reqRefEn = '0; reqRefIdx = '0; reqRefWayVec = '0;
        replRdy = 1'b0; replLookupRspRdy = 1'b0; replLookupVecRsp = '0; replLookupRsp = '0;
        lk_q.delete();
        ref_q.delete();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic drive_ref(input int r, input logic [9:0] idx, input logic [3:0] vec);
        reqRefEn = '0;
        reqRefEn[r] = 1'b1;
        reqRefIdx[r] = idx;
        reqRefWayVec[r] = vec;
    endtask

    task automatic test_reset();
        do_reset();
        replLookupRspRdy = 1'b1;
        #1;
        checks++; if (reqLookupGrant !== 4'b0) $display("FAIL reset_grant: got %b want 0000", reqLookupGrant); else passed++;
        checks++; if (reqRspValid !== 4'b0) $display("FAIL reset_rsp_valid: got %b want 0000", reqRspValid); else passed++;
        checks++; if (replLookupEn !== 1'b0) $display("FAIL reset_lookup_en: got %b want 0", replLookupEn); else passed++;
        checks++; if (replRefEn0 !== 1'b0) $display("FAIL reset_ref_en0: got %b want 0", replRefEn0); else passed++;
        checks++; if (replRefEn1 !== 1'b0) $display("FAIL reset_ref_en1: got %b want 0", replRefEn1); else passed++;
        checks++; if (refDropCnt !== 16'h0) $display("FAIL reset_drop_cnt: got %h want 0000", refDropCnt); else passed++;
    endtask

    task automatic test_fairness();
        int ptr_m, w, o;
        logic [3:0] exp_g;
        do_reset();
        replRdy = 1'b1;
        reqLookupEn = 4'hF;
        for (int r = 0; r < 4; r++) reqLookupIdx[r] = 10'(100 + r);
        replLookupVecRsp = 4'b0100;
        replLookupRsp = 2'd2;
        ptr_m = 0;
        for (int c = 0; c < 6; c++) begin
            if (c == 5) reqLookupEn = '0;
            replLookupRspRdy = (lk_q.size() != 0);
            #1;
            if (lk_q.size() != 0) begin
                o = lk_q.pop_front();
                checks++; if (reqRspValid !== 4'(1 << o)) $display("FAIL fair_rsp_valid c%0d: got %b want %b", c, reqRspValid, 4'(1 << o)); else passed++;
                checks++; if ({reqRspVec, reqRspIdx} !== 6'b0100_10) $display("FAIL fair_rsp_data c%0d: got %b/%0d want 0100/2", c, reqRspVec, reqRspIdx); else passed++;
            end
            w = model_pick(reqLookupEn, ptr_m);
            exp_g = (w < 0) ? 4'b0 : 4'(1 << w);
            checks++; if (reqLookupGrant !== exp_g) $display("FAIL fair_grant c%0d: got %b want %b", c, reqLookupGrant, exp_g); else passed++;
            checks++; if (replLookupEn !== (w >= 0)) $display("FAIL fair_lookup_en c%0d: got %b want %b", c, replLookupEn, (w >= 0)); else passed++;
            if (w >= 0) begin
                checks++; if (replLookupIdx !== 10'(100 + w)) $display("FAIL fair_lookup_idx c%0d: got %0d want %0d", c, replLookupIdx, 100 + w); else passed++;
                lk_q.push_back(w);
                ptr_m = (w + 1) % 4;
            end
            tick();
        end
    endtask

    task automatic test_not_ready();
        int o;
        do_reset();
        reqLookupEn = 4'b0101;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (reqLookupGrant !== 4'b0) $display("FAIL nrdy_grant c%0d: got %b want 0000", c, reqLookupGrant); else passed++;
            checks++; if (replLookupEn !== 1'b0) $display("FAIL nrdy_lookup_en c%0d: got %b want 0", c, replLookupEn); else passed++;
            tick();
        end
        replRdy = 1'b1;
        #1;
        checks++; if (reqLookupGrant !== 4'b0001) $display("FAIL rdy_grant0: got %b want 0001", reqLookupGrant); else passed++;
        lk_q.push_back(0);
        tick();
        reqLookupEn = 4'b0100;
        replLookupRspRdy = 1'b1;
        #1;
        o = lk_q.pop_front();
        checks++; if (reqRspValid !== 4'(1 << o)) $display("FAIL rdy_rsp0: got %b want %b", reqRspValid, 4'(1 << o)); else passed++;
        checks++; if (reqLookupGrant !== 4'b0100) $display("FAIL rdy_grant2: got %b want 0100", reqLookupGrant); else passed++;
        lk_q.push_back(2);
        tick();
        reqLookupEn = 4'b0000;
        #1;
        o = lk_q.pop_front();
        checks++; if (reqRspValid !== 4'(1 << o)) $display("FAIL rdy_rsp2: got %b want %b", reqRspValid, 4'(1 << o)); else passed++;
    endtask

    task automatic test_reset_mid_flight();
        do_reset();
        replRdy = 1'b1;
        reqLookupEn = 4'b0100;
        #1;
        checks++; if (reqLookupGrant !== 4'b0100) $display("FAIL mid_grant: got %b want 0100", reqLookupGrant); else passed++;
        tick();
        reqLookupEn = 4'b0000;
        reset = 1'b1;
        replLookupRspRdy = 1'b1;
        #1;
        checks++; if (reqRspValid !== 4'b0) $display("FAIL mid_rsp_t1: got %b want 0000", reqRspValid); else passed++;
        tick();
        reset = 1'b0;
        #1;
        checks++; if (reqRspValid !== 4'b0) $display("FAIL mid_rsp_t2: got %b want 0000", reqRspValid); else passed++;
        tick();
        replLookupRspRdy = 1'b0;
        reqLookupEn = 4'hF;
        #1;
        checks++; if (reqLookupGrant !== 4'b0001) $display("FAIL mid_ptr_restart: got %b want 0001", reqLookupGrant); else passed++;
        reqLookupEn = 4'b0000;
        tick();
    endtask

    task automatic test_drain_pairing();
        logic [13:0] e0, e1;
        do_reset();
        replRdy = 1'b1;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin drive_ref(0, 10'd5, 4'b0001); ref_q.push_back({10'd5, 4'b0001}); end
            else        begin drive_ref(1, 10'd9, 4'b0100); ref_q.push_back({10'd9, 4'b0100}); end
            tick();
            reqRefEn = '0;
            tick();
            e0 = ref_q.pop_front();
            checks++; if (replRefEn0 !== 1'b1) $display("FAIL single_en0 k%0d: got %b want 1", k, replRefEn0); else passed++;
            checks++; if ({replRefIdx0, replRefWayVec0} !== e0) $display("FAIL single_data0 k%0d: got %h want %h", k, {replRefIdx0, replRefWayVec0}, e0); else passed++;
            checks++; if (replRefEn1 !== 1'b0) $display("FAIL single_en1 k%0d: got %b want 0", k, replRefEn1); else passed++;
            tick();
            checks++; if (replRefEn0 !== 1'b0) $display("FAIL single_idle k%0d: got %b want 0", k, replRefEn0); else passed++;
        end
        replRdy = 1'b0;
        drive_ref(0, 10'd5, 4'b0001); ref_q.push_back({10'd5, 4'b0001});
        tick();
        drive_ref(1, 10'd9, 4'b0100); ref_q.push_back({10'd9, 4'b0100});
        tick();
        reqRefEn = '0;
        replRdy = 1'b1;
        tick();
        e0 = ref_q.pop_front();
        e1 = ref_q.pop_front();
        checks++; if ({replRefEn0, replRefEn1} !== 2'b11) $display("FAIL pair_en: got %b%b want 11", replRefEn0, replRefEn1); else passed++;
        checks++; if ({replRefIdx0, replRefWayVec0} !== e0) $display("FAIL pair_data0: got %h want %h", {replRefIdx0, replRefWayVec0}, e0); else passed++;
        checks++; if ({replRefIdx1, replRefWayVec1} !== e1) $display("FAIL pair_data1: got %h want %h", {replRefIdx1, replRefWayVec1}, e1); else passed++;
    endtask

    task automatic test_drops();
        logic [13:0] e;
        do_reset();
        replRdy = 1'b1;
        reqRefEn = 4'hF;
        for (int r = 0; r < 4; r++) begin
            reqRefIdx[r] = 10'(30 + r);
            reqRefWayVec[r] = 4'(1 << r);
        end
        ref_q.push_back({10'd30, 4'b0001});
        tick();
        reqRefEn = '0;
        checks++; if (refDropCnt !== 16'd3) $display("FAIL drop_all4: got %0d want 3", refDropCnt); else passed++;
        tick();
        e = ref_q.pop_front();
        checks++; if ({replRefEn0, replRefIdx0, replRefWayVec0} !== {1'b1, e}) $display("FAIL drop_winner: got %b/%h want 1/%h", replRefEn0, {replRefIdx0, replRefWayVec0}, e); else passed++;
        // Fill to capacity with the drain stalled.
        replRdy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive_ref(i % 4, 10'(40 + i), 4'(1 << (i % 4)));
            ref_q.push_back({10'(40 + i), 4'(1 << (i % 4))});
            tick();
        end
        drive_ref(0, 10'd60, 4'b0001);
        tick();
        checks++; if (refDropCnt !== 16'd4) $display("FAIL drop_full: got %0d want 4", refDropCnt); else passed++;
        drive_ref(1, 10'd61, 4'b0010);
        ref_q.push_back({10'd61, 4'b0010});
        replRdy = 1'b1;
        tick();
        reqRefEn = '0;
        checks++; if (refDropCnt !== 16'd4) $display("FAIL drop_full_drain: got %0d want 4", refDropCnt); else passed++;
        for (int c = 0; c < 12; c++) begin
            if (replRefEn0) begin
                checks++;
                if (ref_q.size() == 0) $display("FAIL drain_extra0 c%0d: got %h want none", c, {replRefIdx0, replRefWayVec0});
                else begin
                    e = ref_q.pop_front();
                    if ({replRefIdx0, replRefWayVec0} !== e) $display("FAIL drain_order0 c%0d: got %h want %h", c, {replRefIdx0, replRefWayVec0}, e); else passed++;
                end
            end
            if (replRefEn1) begin
                checks++;
                if (ref_q.size() == 0) $display("FAIL drain_extra1 c%0d: got %h want none", c, {replRefIdx1, replRefWayVec1});
                else begin
                    e = ref_q.pop_front();
                    if ({replRefIdx1, replRefWayVec1} !== e) $display("FAIL drain_order1 c%0d: got %h want %h", c, {replRefIdx1, replRefWayVec1}, e); else passed++;
                end
            end
            tick();
        end
        checks++; if (ref_q.size() != 0) $display("FAIL drain_left: got %0d entries undrained want 0", ref_q.size()); else passed++;
    endtask

    task automatic test_saturation();
        do_reset();
        replRdy = 1'b1;
        reqRefEn = 4'hF;
        repeat (23334) tick();  // 3 drops per cycle -> 70002 total
        reqRefEn = '0;
        checks++; if (refDropCnt !== 16'hFFFF) $display("FAIL sat_value: got %h want ffff", refDropCnt); else passed++;
        reqRefEn = 4'hF;
        tick();
        reqRefEn = '0;
        checks++; if (refDropCnt !== 16'hFFFF) $display("FAIL sat_hold: got %h want ffff", refDropCnt); else passed++;
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_not_ready();
        test_reset_mid_flight();
        test_drain_pairing();
        test_drops();
        test_saturation();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/cci_mpf_prim_repl_arb.md
Name: cci_mpf_prim_repl_arb

Overview:
- Shares one replacement-policy instance (random or LRU, identical interface) among N_REQ requesters.
- Arbitrates single-ported victim lookups round-robin and routes each 1-cycle-latency response back to its owner.
- Buffers best-effort reference updates in a small FIFO and drains up to two per cycle into the policy's ref ports 0 and 1.
- Sits between cache pipeline clients (e.g. per-channel tag pipelines) and the policy module.

Parameters:
N_WAYS, 4, associativity; width of way vectors
N_ENTRIES, 1024, sets tracked by policy; index width $clog2(N_ENTRIES)
N_REQ, 4, number of requesters (>=2)
REF_FIFO_DEPTH, 8, reference FIFO entries (power of 2, >=2)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
reqLookupEn  in  N_REQ  per-requester lookup request, held until granted
reqLookupIdx  in  N_REQ x IDX  set index per requester
reqLookupGrant  out  N_REQ  one-hot grant, combinational from current request/pointer
reqRspValid  out  N_REQ  one-hot: response for that requester valid this cycle
reqRspVec  out  N_WAYS  victim one-hot way (broadcast)
reqRspIdx  out  $clog2(N_WAYS)  victim way index (broadcast)
reqRefEn  in  N_REQ  reference update request, not held (fire-and-forget)
reqRefIdx  in  N_REQ x IDX  reference set index
reqRefWayVec  in  N_REQ x N_WAYS  referenced ways
replRdy  in  1  policy rdy
replLookupIdx  out  IDX  to policy lookupIdx
replLookupEn  out  1  to policy lookupEn
replLookupRspRdy  in  1  from policy
replLookupVecRsp  in  N_WAYS  from policy
replLookupRsp  in  $clog2(N_WAYS)  from policy
replRefIdx0/replRefWayVec0/replRefEn0  out  IDX/N_WAYS/1  to policy port 0
replRefIdx1/replRefWayVec1/replRefEn1  out  IDX/N_WAYS/1  to policy port 1
refDropCnt  out  16  saturating count of discarded references

Behaviour:
- Reset outputs: grants 0, reqRspValid 0, replLookupEn 0, replRefEn0/1 0, FIFO empty, RR pointers 0, refDropCnt 0. Data outputs don't-care.
- Lookup arbitration:
  - While replRdy=0: no grant.
  - Otherwise grant the first asserted reqLookupEn at or after lookupPtr, searching cyclically upward.
  - replLookupEn = |grant; replLookupIdx = winner's index, muxed combinationally.
  - On a grant, lookupPtr <= winner+1 mod N_REQ, and the winner id is registered into ownerQ.
- Response routing:
  - When replLookupRspRdy=1, reqRspValid = onehot(ownerQ).
  - reqRspVec and reqRspIdx pass through from the policy.
  - Latency: request granted in cycle T gets its response in cycle T+1. One lookup per cycle, fully pipelined.
  - Reset during an in-flight lookup: the response cycle after reset must show reqRspValid=0.
- Reference capture:
  - At most one reqRefEn is accepted per cycle, picked round-robin from refPtr (independent of lookupPtr).
  - If the FIFO is full after this cycle's drain, the winner is also dropped.
  - Every unaccepted asserted reqRefEn bit increments refDropCnt by its popcount; the counter saturates at 16'hFFFF.
- Reference drain, same cycle, FIFO entries available at cycle start:
  - count>=2: pop two; head goes to port 0, next to port 1.
  - count==1: pop head to port 0 only.
  - Ref outputs are registered; replRefEn0/1 assert the cycle after the pop.
- Simultaneous push and pop: occupancy updates by push-pops. Full is determined after the same-cycle pop, so a full FIFO still accepts when it drains.
- Wrap-around: FIFO pointers are $clog2(DEPTH)+1 bits; full = MSBs differ and the rest are equal.

Decomposition:
- Shared package cci_mpf_prim_repl_pkg: t_repl_set_idx, t_repl_way_vec, t_repl_way_idx (parameterised via localparams), plus function rr_pick(req, ptr) returning the one-hot winner.
- Sub-module cci_mpf_prim_repl_ref_fifo: 1 push, up to 2 pops per cycle, with count output.
- Arbitration and routing stay in the top level.

Test Plan:
- Lookup fairness: all 4 reqLookupEn held, replRdy=1, ptr=0 -> grants 0,1,2,3,0 in consecutive cycles; the response for each appears on reqRspValid one-hot exactly one cycle later.
- Not ready: replRdy=0 for 3 cycles with requests 0b0101 -> no grants, replLookupEn=0. After replRdy rises -> grant 0b0001, then 0b0100.
- Reset mid-flight: grant to req 2 in cycle T, reset in T+1 -> reqRspValid=0 in T+1 and T+2; ptr restarts at 0.
- Drain pairing: push refs (idx 5, vec 0001) and (idx 9, vec 0100) on separate cycles with no further pushes -> first drains alone on port 0, second alone on port 0; with 2 queued at once -> idx 5 on port 0 and idx 9 on port 1 in the same cycle.
- Drops: all 4 reqRefEn asserted for 1 cycle -> 1 accepted, refDropCnt=3. Prefill to 8 entries, then a push coinciding with a 2-pop -> accepted, no drop.
- Saturation: force 70000 dropped references -> refDropCnt holds 16'hFFFF.
